// File: rtl/ifu_pkg.sv
// Shared types and constants for the npc instruction fetch unit.
package ifu_pkg;
  localparam int XLEN   = 64;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_RST = 64'h8000_0000;

  typedef enum logic {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              filled;
  } ifu_entry_t;
endpackage

// File: rtl/ifu_buf.sv
// Two-entry in-order fetch buffer: allocate on request, fill on response, pop on
// delivery, flush on redirect.
module ifu_buf
  import ifu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc,
  input  logic [XLEN-1:0]   allocPc,
  input  logic              fill,
  input  logic [INST_W-1:0] fillInst,
  input  logic              pop,
  output logic              headReady,
  output logic [XLEN-1:0]   headPc,
  output logic [INST_W-1:0] headInst,
  output logic [1:0]        allocCnt,
  output logic [1:0]        unfilledCnt
);
  ifu_entry_t entries [2];
  logic [1:0] used;
  logic       headPtr;
  logic       tailPtr;
  logic       fillPtr;

  // Entries fill in allocation order, so the oldest unfilled one is the head
  // unless the head has already returned.
  always_comb begin
    fillPtr = (used[headPtr] && !entries[headPtr].filled) ? headPtr : ~headPtr;
  end

  assign allocCnt    = {1'b0, used[0]} + {1'b0, used[1]};
  assign unfilledCnt = {1'b0, used[0] & ~entries[0].filled}
                     + {1'b0, used[1] & ~entries[1].filled};
  assign headReady   = used[headPtr] & entries[headPtr].filled;
  assign headPc      = entries[headPtr].pc;
  assign headInst    = entries[headPtr].inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) entries[i] <= '0;
      used    <= '0;
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
    end else if (flush) begin
      used    <= '0;
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
    end else begin
      if (pop) begin
        used[headPtr] <= 1'b0;
        headPtr       <= ~headPtr;
      end
      if (fill) begin
        entries[fillPtr].filled <= 1'b1;
        entries[fillPtr].inst   <= fillInst;
      end
      // When full, a pop frees the slot this allocation reuses; allocation wins.
      if (alloc) begin
        used[tailPtr]           <= 1'b1;
        entries[tailPtr].pc     <= allocPc;
        entries[tailPtr].filled <= 1'b0;
        tailPtr                 <= ~tailPtr;
      end
    end
  end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues imem requests, buffers two
// instructions for decode and discards stale responses after a redirect.
module ifu
  import ifu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc,
  output ifu_state_e        dbgState
);
  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high; valid never waits on ready except imem_req_valid, which may rise when
  // the decoder frees a slot in the same cycle. Responses have no ready.
  ifu_state_e      state;
  ifu_state_e      stateNext;
  logic [XLEN-1:0] fetchPc;
  logic [1:0]      dropCnt;
  logic [1:0]      dropCntNext;
  logic [1:0]      allocCnt;
  logic [1:0]      unfilledCnt;
  logic            reqFire;
  logic            outFire;
  logic            rspDrop;
  logic            rspFill;
  logic            unusedPcLow;

  assign unusedPcLow = ^redirect_pc[1:0];
  assign dbgState    = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RESET;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext      = state;
    imem_req_valid = 1'b0;
    unique case (state)
      S_RESET: stateNext = S_RUN;
      S_RUN:   imem_req_valid = !redirect_valid && (allocCnt < 2'd2 || outFire);
    endcase
  end

  assign imem_req_addr = fetchPc;
  assign reqFire       = imem_req_valid & imem_req_ready;
  assign outFire       = out_valid & out_ready;
  assign rspDrop       = imem_rsp_valid & (dropCnt != 2'd0);
  assign rspFill       = imem_rsp_valid & (dropCnt == 2'd0) & (unfilledCnt != 2'd0);

  // Unfilled entries flushed by a redirect still owe a response; count them so
  // those responses are swallowed rather than landing in the new stream.
  always_comb begin
    dropCntNext = dropCnt - {1'b0, rspDrop};
    if (redirect_valid) dropCntNext = dropCntNext + unfilledCnt - {1'b0, rspFill};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc <= PC_RST;
      dropCnt <= 2'd0;
    end else begin
      dropCnt <= dropCntNext;
      if (redirect_valid) fetchPc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (reqFire)   fetchPc <= fetchPc + 64'd4;
    end
  end

  ifu_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc      (reqFire),
    .allocPc    (fetchPc),
    .fill       (rspFill),
    .fillInst   (imem_rsp_inst),
    .pop        (outFire),
    .headReady  (out_valid),
    .headPc     (out_pc),
    .headInst   (out_inst),
    .allocCnt   (allocCnt),
    .unfilledCnt(unfilledCnt)
  );

  responseExpected: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && dropCnt == 2'd0 && unfilledCnt == 2'd0));
endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a cycle table for reset/startup/stall/redirect,
// then memory-model sequences for streaming, backpressure and redirect cases.
module tb_ifu;
  import ifu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_inst;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [XLEN-1:0]   out_pc;
  ifu_state_e        dbgState;

  ifu dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_inst (imem_rsp_inst),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .dbgState      (dbgState)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstN, outRdy, reqRdy, rspV;
    logic [31:0] rspInst;
    logic        redirV;
    logic [63:0] redirPc;
    logic        eReqV;
    logic [63:0] eAddr;
    logic        eOutV, chkData;
    logic [63:0] ePc;
    logic [31:0] eInst;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  int          nVec = 0;
  int          nErr = 0;
  int          cyc, reqCnt, delivCnt, firstDeliv, lastDeliv, memLat;
  logic        drvOutReady, drvRedir;
  logic [63:0] drvRedirPc;
  logic [63:0] exp_q[$];
  mreq_t       memQ[$];
  vec_t        vecs[17];

  function automatic vec_t mk(logic rn, logic ordy, logic qrdy, logic rv, logic [31:0] ri,
                              logic dv, logic [63:0] dpc, logic erv, logic [63:0] ea,
                              logic eov, logic cd, logic [63:0] ep, logic [31:0] ei);
    vec_t v;
    v.rstN = rn; v.outRdy = ordy; v.reqRdy = qrdy; v.rspV = rv; v.rspInst = ri;
    v.redirV = dv; v.redirPc = dpc; v.eReqV = erv; v.eAddr = ea;
    v.eOutV = eov; v.chkData = cd; v.ePc = ep; v.eInst = ei;
    return v;
  endfunction

  function automatic logic [31:0] instOf(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock of the memory model / decoder driver; samples on the falling edge.
  task automatic tick();
    logic [63:0] e;
    mreq_t       m;
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_inst  = '0;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      m = memQ.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_inst  = instOf(m.addr);
    end
    out_ready      = drvOutReady;
    redirect_valid = drvRedir;
    redirect_pc    = drvRedirPc;
    imem_req_ready = 1'b1;
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      m.addr = imem_req_addr;
      m.due  = cyc + memLat;
      memQ.push_back(m);
      reqCnt++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_pc", out_pc, '1);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_inst", {32'd0, out_inst}, {32'd0, instOf(e)});
      end
      if (delivCnt == 0) firstDeliv = cyc;
      lastDeliv = cyc;
      delivCnt++;
    end
    cyc++;
  endtask

  task automatic runUntil(input int n, input int budget, input string name);
    int k = 0;
    while (delivCnt < n && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_delivered"}, 64'(delivCnt), 64'(n));
  endtask

  task automatic waitReqs(input int n, input string name);
    int k = 0;
    while (reqCnt < n && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_reqs"}, 64'(reqCnt), 64'(n));
  endtask

  task automatic doReset();
    rst = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_inst = '0;
    redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; imem_req_ready = 1'b0;
    memQ.delete(); exp_q.delete();
    drvRedir = 1'b0; drvRedirPc = '0; drvOutReady = 1'b1;
    reqCnt = 0; delivCnt = 0; firstDeliv = 0; lastDeliv = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc = 0;
  endtask

  task automatic seqDoubleRedirect(input int gap);
    doReset();
    memLat = 3;
    waitReqs(2, "dr");
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h200 + 64'(4 * i));
    drvRedir = 1'b1; drvRedirPc = 64'h100;
    tick();
    for (int i = 1; i < gap; i++) begin
      drvRedir = 1'b0;
      tick();
    end
    drvRedir = 1'b1; drvRedirPc = 64'h200;
    tick();
    chk("dr_hold_req_valid", {63'd0, imem_req_valid}, 64'd0);
    drvRedir = 1'b0;
    tick();
    chk("dr_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("dr_req_addr", imem_req_addr, 64'h200);
    runUntil(4, 80, "dr");
  endtask

  initial begin
    logic [63:0] b;
    b = PC_RST;
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_inst = '0;
    out_ready = 1'b1;
    drvOutReady = 1'b1; drvRedir = 1'b0; drvRedirPc = '0;
    memLat = 1; cyc = 0; reqCnt = 0; delivCnt = 0; firstDeliv = 0; lastDeliv = 0;

    // rst  ordy qrdy rspV inst          redir pc            | reqV addr            outV chk pc               inst
    vecs[0]  = mk(0, 1, 1, 0, 32'h0,        0, 64'h0,           0, b,               0, 1, 64'h0,            32'h0);
    vecs[1]  = mk(0, 1, 1, 0, 32'h0,        0, 64'h0,           0, b,               0, 1, 64'h0,            32'h0);
    vecs[2]  = mk(0, 1, 1, 0, 32'h0,        0, 64'h0,           0, b,               0, 1, 64'h0,            32'h0);
    vecs[3]  = mk(1, 1, 1, 0, 32'h0,        0, 64'h0,           0, b,               0, 0, 64'h0,            32'h0);
    vecs[4]  = mk(1, 1, 0, 0, 32'h0,        0, 64'h0,           1, b,               0, 0, 64'h0,            32'h0);
    vecs[5]  = mk(1, 1, 1, 0, 32'h0,        0, 64'h0,           1, b,               0, 0, 64'h0,            32'h0);
    vecs[6]  = mk(1, 1, 1, 1, 32'h0000_0013, 0, 64'h0,          1, b + 64'h4,       0, 0, 64'h0,            32'h0);
    vecs[7]  = mk(1, 1, 1, 1, 32'h0010_0093, 0, 64'h0,          1, b + 64'h8,       1, 1, b,                32'h0000_0013);
    vecs[8]  = mk(1, 1, 1, 1, 32'h0020_0113, 0, 64'h0,          1, b + 64'hC,       1, 1, b + 64'h4,        32'h0010_0093);
    vecs[9]  = mk(1, 0, 1, 1, 32'h0030_0193, 0, 64'h0,          0, b + 64'h10,      1, 1, b + 64'h8,        32'h0020_0113);
    vecs[10] = mk(1, 0, 1, 0, 32'h0,        0, 64'h0,           0, b + 64'h10,      1, 1, b + 64'h8,        32'h0020_0113);
    vecs[11] = mk(1, 1, 1, 0, 32'h0,        0, 64'h0,           1, b + 64'h10,      1, 1, b + 64'h8,        32'h0020_0113);
    vecs[12] = mk(1, 1, 1, 1, 32'h0040_0213, 0, 64'h0,          1, b + 64'h14,      1, 1, b + 64'hC,        32'h0030_0193);
    vecs[13] = mk(1, 1, 1, 1, 32'h0050_0293, 1, 64'h9000_0103,  0, b + 64'h18,      1, 1, b + 64'h10,       32'h0040_0213);
    vecs[14] = mk(1, 1, 1, 0, 32'h0,        0, 64'h0,           1, 64'h9000_0100,   0, 0, 64'h0,            32'h0);
    vecs[15] = mk(1, 1, 1, 1, 32'h0000_006F, 0, 64'h0,          1, 64'h9000_0104,   0, 0, 64'h0,            32'h0);
    vecs[16] = mk(1, 1, 1, 0, 32'h0,        0, 64'h0,           1, 64'h9000_0108,   1, 1, 64'h9000_0100,    32'h0000_006F);

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      rst            = vecs[i].rstN;
      out_ready      = vecs[i].outRdy;
      imem_req_ready = vecs[i].reqRdy;
      imem_rsp_valid = vecs[i].rspV;
      imem_rsp_inst  = vecs[i].rspInst;
      redirect_valid = vecs[i].redirV;
      redirect_pc    = vecs[i].redirPc;
      @(negedge clk);
      chk($sformatf("v%0d_req_valid", i), {63'd0, imem_req_valid}, {63'd0, vecs[i].eReqV});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].eAddr);
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].eOutV});
      if (vecs[i].chkData) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].ePc);
        chk($sformatf("v%0d_out_inst", i), {32'd0, out_inst}, {32'd0, vecs[i].eInst});
      end
    end

    // Streaming with a 1-cycle memory: first delivery two cycles after the first request.
    doReset();
    memLat = 1;
    for (int i = 0; i < 100; i++) exp_q.push_back(PC_RST + 64'(4 * i));
    runUntil(100, 150, "stream");
    chk("stream_first_cycle", 64'(firstDeliv), 64'd2);
    chk("stream_span", 64'(lastDeliv - firstDeliv), 64'd99);

    // Decoder stall: buffer fills to two and fetching stops until released.
    doReset();
    memLat = 1;
    for (int i = 0; i < 20; i++) exp_q.push_back(PC_RST + 64'(4 * i));
    runUntil(3, 20, "bp_pre");
    drvOutReady = 1'b0;
    repeat (5) tick();
    chk("bp_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("bp_outstanding", 64'(reqCnt - delivCnt), 64'd2);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    drvOutReady = 1'b1;
    runUntil(20, 60, "bp");

    // Redirect with two responses still in flight on a 3-cycle memory.
    doReset();
    memLat = 3;
    waitReqs(2, "rd");
    for (int i = 0; i < 6; i++) exp_q.push_back(64'h8000_0100 + 64'(4 * i));
    drvRedir = 1'b1; drvRedirPc = 64'h8000_0103;
    tick();
    drvRedir = 1'b0;
    chk("rd_hold_req_valid", {63'd0, imem_req_valid}, 64'd0);
    tick();
    chk("rd_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("rd_req_addr", imem_req_addr, 64'h8000_0100);
    runUntil(6, 60, "rd");

    seqDoubleRedirect(1);
    seqDoubleRedirect(2);

    // Asynchronous reset in the middle of a response stream.
    doReset();
    memLat = 2;
    for (int i = 0; i < 10; i++) exp_q.push_back(PC_RST + 64'(4 * i));
    runUntil(5, 40, "ar_pre");
    #2 rst = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("ar_req_addr", imem_req_addr, PC_RST);
    chk("ar_out_pc", out_pc, 64'd0);
    chk("ar_out_inst", {32'd0, out_inst}, 64'd0);
    chk("ar_state", {63'd0, dbgState}, {63'd0, S_RESET});
    doReset();
    memLat = 2;
    for (int i = 0; i < 10; i++) exp_q.push_back(PC_RST + 64'(4 * i));
    runUntil(5, 40, "ar_post");
    chk("ar_state_run", {63'd0, dbgState}, {63'd0, S_RUN});

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
